// File: rtl/color_analysis_deadlock_report_ctrl.sv
// color_analysis_deadlock_report_ctrl
//
// Supervisory controller behind the color_analysis dataflow deadlock monitor.
// A raw block indication is confirmed only after THRESH consecutive asserted
// cycles. On the confirm cycle the per-process idle / channel-block /
// AXIS-block vectors are snapshotted. One status word per process is then
// streamed out, and a sticky deadlock flag is held until software clears it.
//
// Optional feature macro: COLOR_ANALYSIS_DLRPT_FILTER_EN
//   When defined, purely idle processes (chan_block=0 and axis_block=0) are
//   skipped in the report at zero cycle cost. If no process is blocked, the
//   controller goes from confirm straight to HOLD, emits no words, and still
//   sets the flag.
//
// Ports
//   clock, reset           : clock; asynchronous active-high reset
//   enable                 : arms detection; low drops ARMED back to IDLE
//   block_in               : registered block output of the monitor
//   idle_vec               : per-process idle indications      [NUM_PROC]
//   chan_block_vec         : per-process channel blocks        [NUM_PROC]
//   axis_block_vec         : per-process AXIS blocks           [NUM_PROC]
//   clear                  : single-cycle acknowledge / rearm pulse
//   rpt_valid/ready/data/last : report stream
//                            data = {idx[7:0], 5'b0, idle, chan, axis}
//   deadlock_flag          : sticky confirmed-deadlock flag
//   stall_cycles           : saturating consecutive block_in count
//   dbg_state              : FSM state (0 IDLE, 1 ARMED, 2 REPORT, 3 HOLD)
//
// Report handshake: a word transfers on a rising edge where rpt_valid and
// rpt_ready are both 1. While rpt_valid=1 and rpt_ready=0, rpt_data and
// rpt_last stay stable. rpt_valid never drops before the word is accepted,
// except when clear aborts the report.
module color_analysis_deadlock_report_ctrl #(
  parameter int NUM_PROC = 12,
  parameter int THRESH   = 16,
  parameter int CNT_W    = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                block_in,
  input  logic [NUM_PROC-1:0] idle_vec,
  input  logic [NUM_PROC-1:0] chan_block_vec,
  input  logic [NUM_PROC-1:0] axis_block_vec,
  input  logic                clear,
  output logic                rpt_valid,
  input  logic                rpt_ready,
  output logic [15:0]         rpt_data,
  output logic                rpt_last,
  output logic                deadlock_flag,
  output logic [CNT_W-1:0]    stall_cycles,
  output logic [1:0]          dbg_state
);

  localparam int IDX_W = (NUM_PROC > 1) ? $clog2(NUM_PROC) : 1;
  localparam logic [CNT_W-1:0] THR_M1 = CNT_W'(THRESH - 1);
  localparam bit ONE_SHOT = (THRESH == 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARMED  = 2'd1,
    S_REPORT = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_confirm;
  logic [CNT_W-1:0]    r_stall;
  logic                r_flag;
  logic [IDX_W-1:0]    r_idx;
  logic [NUM_PROC-1:0] r_idle;
  logic [NUM_PROC-1:0] r_chan;
  logic [NUM_PROC-1:0] r_axis;

  // First index to report at confirm, next index after r_idx, and whether
  // r_idx is the final word of the report.
  logic                w_first_ok;
  logic [IDX_W-1:0]    w_first;
  logic [IDX_W-1:0]    w_next;
  logic                w_last;

`ifdef COLOR_ANALYSIS_DLRPT_FILTER_EN
  // Lowest set bit of m at or above start: {found, index}. The loop runs
  // downward, so the last hit it records is the lowest one.
  function automatic logic [IDX_W:0] find_from(input logic [NUM_PROC-1:0] m,
                                               input int start);
    logic [IDX_W:0] res;
    res = '0;
    for (int i = NUM_PROC - 1; i >= 0; i--) begin
      if (m[i] && (i >= start)) res = {1'b1, IDX_W'(i)};
    end
    return res;
  endfunction

  logic [IDX_W:0] w_first_srch;
  logic [IDX_W:0] w_next_srch;

  // The first search uses the live vectors because the snapshot is only
  // being written on the confirm edge.
  assign w_first_srch = find_from(chan_block_vec | axis_block_vec, 0);
  assign w_next_srch  = find_from(r_chan | r_axis, int'(r_idx) + 1);
  assign w_first_ok   = w_first_srch[IDX_W];
  assign w_first      = w_first_srch[IDX_W-1:0];
  assign w_next       = w_next_srch[IDX_W-1:0];
  assign w_last       = !w_next_srch[IDX_W];
`else
  assign w_first_ok = 1'b1;
  assign w_first    = '0;
  assign w_next     = r_idx + 1'b1;
  assign w_last     = (r_idx == IDX_W'(NUM_PROC - 1));
`endif

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic. clear has priority over detection and over a
  // concurrent handshake.
  always_comb begin
    w_state_nxt = r_state;
    w_confirm   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!clear && enable && block_in) begin
          if (ONE_SHOT) w_confirm = 1'b1;
          else          w_state_nxt = S_ARMED;
        end
      end
      S_ARMED: begin
        if (clear || !enable || !block_in) w_state_nxt = S_IDLE;
        else if (r_stall == THR_M1)        w_confirm = 1'b1;
      end
      S_REPORT: begin
        if (clear)                  w_state_nxt = S_IDLE;
        else if (rpt_ready && w_last) w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (clear) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_confirm) w_state_nxt = w_first_ok ? S_REPORT : S_HOLD;
  end

  // Stall counter: counts only while detecting, frozen in REPORT and HOLD.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_stall <= '0;
    end else if (clear) begin
      r_stall <= '0;
    end else begin
      case (r_state)
        S_IDLE:  r_stall <= (enable && block_in) ? CNT_W'(1) : '0;
        S_ARMED: begin
          if (!(enable && block_in)) r_stall <= '0;
          else if (r_stall != '1)    r_stall <= r_stall + 1'b1;
        end
        default: r_stall <= r_stall;
      endcase
    end
  end

  // Snapshot, report index and sticky flag
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_flag <= 1'b0;
      r_idx  <= '0;
      r_idle <= '0;
      r_chan <= '0;
      r_axis <= '0;
    end else begin
      if (w_confirm) begin
        r_flag <= 1'b1;
        r_idx  <= w_first;
        r_idle <= idle_vec;
        r_chan <= chan_block_vec;
        r_axis <= axis_block_vec;
      end else if (clear) begin
        r_flag <= 1'b0;
      end else if (r_state == S_REPORT && rpt_ready && !w_last) begin
        r_idx <= w_next;
      end
    end
  end

  assign rpt_valid     = (r_state == S_REPORT);
  assign rpt_last      = rpt_valid && w_last;
  assign rpt_data      = rpt_valid ? {8'(r_idx), 5'b0, r_idle[r_idx],
                                      r_chan[r_idx], r_axis[r_idx]} : 16'h0000;
  assign deadlock_flag = r_flag;
  assign stall_cycles  = r_stall;
  assign dbg_state     = r_state;

endmodule
